// File: rtl/s_to_p_rx_if.sv
// rtl/s_to_p_rx_if.sv - serial lanes in, reassembled words out, valid/ready handshake
interface s_to_p_rx_if #(
    parameter int BITS_TO_RECEIVE = 7
);
    logic                       ss_valid;
    logic                       ss_Flip;
    logic                       ss_Rotate;
    logic                       ss_Polarity;
    logic                       ll_ready;
    logic                       ll_valid;
    logic [BITS_TO_RECEIVE-1:0] ll_Flip;
    logic [BITS_TO_RECEIVE-1:0] ll_Rotate;
    logic [BITS_TO_RECEIVE-1:0] ll_Polarity;

    modport master (
        output ss_valid, ss_Flip, ss_Rotate, ss_Polarity, ll_ready,
        input  ll_valid, ll_Flip, ll_Rotate, ll_Polarity
    );

    modport slave (
        input  ss_valid, ss_Flip, ss_Rotate, ss_Polarity, ll_ready,
        output ll_valid, ll_Flip, ll_Rotate, ll_Polarity
    );
endinterface

// File: rtl/s_to_p_rx.sv
// rtl/s_to_p_rx.sv - three-lane serial-to-parallel receiver, optional STOP_RX_FRAME_CNT_EN frame counter
module s_to_p_rx #(
    parameter int BITS_TO_RECEIVE = 7,
    parameter int CNT_W           = 3
) (
    input  logic        clk_in,
    input  logic        rst,
    s_to_p_rx_if.slave  bus,
    output logic        frame_err,
    output logic        overrun
`ifdef STOP_RX_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BITS_TO_RECEIVE - 1);

    state_t                     state;
    logic [CNT_W-1:0]           cnt;
    logic [BITS_TO_RECEIVE-1:0] sh_f, sh_r, sh_p;
    logic [BITS_TO_RECEIVE-1:0] word_f, word_r, word_p;

    // Shift contents with the current lane bit merged in at position cnt.
    always_comb begin
        word_f      = sh_f;
        word_r      = sh_r;
        word_p      = sh_p;
        word_f[cnt] = bus.ss_Flip;
        word_r[cnt] = bus.ss_Rotate;
        word_p[cnt] = bus.ss_Polarity;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            sh_f            <= '0;
            sh_r            <= '0;
            sh_p            <= '0;
            bus.ll_valid    <= 1'b0;
            bus.ll_Flip     <= '0;
            bus.ll_Rotate   <= '0;
            bus.ll_Polarity <= '0;
            frame_err       <= 1'b0;
            overrun         <= 1'b0;
`ifdef STOP_RX_FRAME_CNT_EN
            frame_cnt       <= '0;
`endif
        end else begin
            frame_err <= 1'b0;
            if (bus.ll_valid && bus.ll_ready)
                bus.ll_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.ss_valid) begin
                        // Upper bits cleared so a previously aborted frame leaves nothing behind.
                        sh_f  <= {{(BITS_TO_RECEIVE-1){1'b0}}, bus.ss_Flip};
                        sh_r  <= {{(BITS_TO_RECEIVE-1){1'b0}}, bus.ss_Rotate};
                        sh_p  <= {{(BITS_TO_RECEIVE-1){1'b0}}, bus.ss_Polarity};
                        cnt   <= CNT_W'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!bus.ss_valid) begin
                        frame_err <= 1'b1;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (!bus.ll_valid || bus.ll_ready) begin
                            bus.ll_Flip     <= word_f;
                            bus.ll_Rotate   <= word_r;
                            bus.ll_Polarity <= word_p;
                            bus.ll_valid    <= 1'b1;
`ifdef STOP_RX_FRAME_CNT_EN
                            frame_cnt       <= frame_cnt + 16'd1;
`endif
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        sh_f <= word_f;
                        sh_r <= word_r;
                        sh_p <= word_p;
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_s_to_p_rx.sv
// tb/tb_s_to_p_rx.sv - scoreboard bench for s_to_p_rx
module tb_s_to_p_rx;
    logic clk_in = 1'b0;
    logic rst;
    logic frame_err;
    logic overrun;
`ifdef STOP_RX_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    s_to_p_rx_if #(.BITS_TO_RECEIVE(7)) bus ();

    s_to_p_rx #(.BITS_TO_RECEIVE(7), .CNT_W(3)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .bus       (bus.slave),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef STOP_RX_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int err_cycles = 0;
    logic [20:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word must match the oldest expected frame.
    always @(negedge clk_in) begin
        if (!rst && bus.ll_valid && bus.ll_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h expected none",
                         {bus.ll_Flip, bus.ll_Rotate, bus.ll_Polarity});
            end else begin
                chk("word", 32'({bus.ll_Flip, bus.ll_Rotate, bus.ll_Polarity}), 32'(sb.pop_front()));
            end
        end
        if (!rst && frame_err) err_cycles++;
    end

    task automatic send_frame(input logic [6:0] f, input logic [6:0] r, input logic [6:0] p,
                              input int n, input bit push, input bit ready_last);
        if (push) sb.push_back({f, r, p});
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in); #1;
            bus.ss_valid    = 1'b1;
            bus.ss_Flip     = f[i];
            bus.ss_Rotate   = r[i];
            bus.ss_Polarity = p[i];
            if (ready_last && i == n - 1) bus.ll_ready = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in); #1;
            bus.ss_valid    = 1'b0;
            bus.ss_Flip     = 1'bx;
            bus.ss_Rotate   = 1'bx;
            bus.ss_Polarity = 1'bx;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.ss_valid = 1'b0;
        bus.ss_Flip = 1'b0;
        bus.ss_Rotate = 1'b0;
        bus.ss_Polarity = 1'b0;
        bus.ll_ready = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_ll_valid", 32'(bus.ll_valid), 0);
        chk("rst_words", 32'({bus.ll_Flip, bus.ll_Rotate, bus.ll_Polarity}), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
`ifdef STOP_RX_FRAME_CNT_EN
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
`endif
        @(posedge clk_in); #1 rst = 1'b0;

        // Single frame and its latency
        send_frame(7'h55, 7'h0F, 7'h7F, 7, 1, 0);
        idle(1);
        @(negedge clk_in);
        chk("single_valid", 32'(bus.ll_valid), 1);
        chk("single_flip", 32'(bus.ll_Flip), 32'h55);
        chk("single_rotate", 32'(bus.ll_Rotate), 32'h0F);
        chk("single_polarity", 32'(bus.ll_Polarity), 32'h7F);
        @(negedge clk_in);
        chk("single_valid_clear", 32'(bus.ll_valid), 0);
        chk("single_frame_err", 32'(frame_err), 0);

        // Serializer cadence, then zero gap
        send_frame(7'h01, 7'h40, 7'h3C, 7, 1, 0);
        idle(1);
        send_frame(7'h7E, 7'h00, 7'h11, 7, 1, 0);
        idle(1);
        send_frame(7'h01, 7'h40, 7'h3C, 7, 1, 0);
        send_frame(7'h7E, 7'h00, 7'h11, 7, 1, 0);
        idle(3);
        chk("cadence_overrun", 32'(overrun), 0);
        chk("cadence_err_cycles", 32'(err_cycles), 0);
        chk("cadence_drained", 32'(sb.size()), 0);

        // Abort after 4 bits, then a good frame
        send_frame(7'h7F, 7'h7F, 7'h7F, 4, 0, 0);
        idle(4);
        chk("abort_err_cycles", 32'(err_cycles), 1);
        chk("abort_no_valid", 32'(bus.ll_valid), 0);
        send_frame(7'h2A, 7'h00, 7'h00, 7, 1, 0);
        idle(1);
        @(negedge clk_in);
        chk("after_abort_flip", 32'(bus.ll_Flip), 32'h2A);

        // Completion coincident with handshake
        idle(1);
        bus.ll_ready = 1'b0;
        send_frame(7'h05, 7'h05, 7'h05, 7, 1, 0);
        idle(2);
        send_frame(7'h06, 7'h06, 7'h06, 7, 1, 1);
        idle(1);
        @(negedge clk_in);
        chk("simul_valid", 32'(bus.ll_valid), 1);
        chk("simul_flip", 32'(bus.ll_Flip), 32'h06);
        chk("simul_overrun", 32'(overrun), 0);
        idle(2);

        // Backpressure and overrun
        bus.ll_ready = 1'b0;
        send_frame(7'h11, 7'h11, 7'h11, 7, 1, 0);
        idle(1);
        send_frame(7'h22, 7'h22, 7'h22, 7, 0, 0);
        idle(2);
        @(negedge clk_in);
        chk("bp_flip_held", 32'(bus.ll_Flip), 32'h11);
        chk("bp_overrun", 32'(overrun), 1);
        @(posedge clk_in); #1 bus.ll_ready = 1'b1;
        @(posedge clk_in); #1 bus.ll_ready = 1'b0;
        @(negedge clk_in);
        chk("bp_valid_clear", 32'(bus.ll_valid), 0);
        chk("bp_overrun_sticky", 32'(overrun), 1);

        // Reset mid-frame with a word held
        send_frame(7'h33, 7'h33, 7'h33, 7, 0, 0);
        idle(1);
        send_frame(7'h7F, 7'h7F, 7'h7F, 3, 0, 0);
        @(posedge clk_in); #1;
        rst = 1'b1;
        bus.ss_valid = 1'b0;
        @(posedge clk_in); #1 rst = 1'b0;
        @(negedge clk_in);
        chk("mid_rst_valid", 32'(bus.ll_valid), 0);
        chk("mid_rst_words", 32'({bus.ll_Flip, bus.ll_Rotate, bus.ll_Polarity}), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        chk("mid_rst_frame_err", 32'(frame_err), 0);
        bus.ll_ready = 1'b1;
        send_frame(7'h7F, 7'h7F, 7'h7F, 7, 1, 0);
        idle(1);
        @(negedge clk_in);
        chk("post_rst_flip", 32'(bus.ll_Flip), 32'h7F);
        idle(3);
`ifdef STOP_RX_FRAME_CNT_EN
        chk("post_rst_frame_cnt", 32'(frame_cnt), 1);
`endif
        chk("final_drained", 32'(sb.size()), 0);
        chk("final_err_cycles", 32'(err_cycles), 1);
        chk("final_overrun", 32'(overrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
